// File: rtl/servo_pwm_six.sv
// Six-channel servo PWM, double-buffered angles swapped at frame wrap; optional SERVO_CLAMP_EN saturates latched angles.
// New widths reach pwm within one frame + 2 cycles; no backpressure, validIn is a fire-and-forget strobe.
module servo_pwm_six #(
  parameter int unsigned PERIOD_CYCLES = 2000000,
  parameter int unsigned MIN_PULSE     = 100000,
  parameter int unsigned SCALE         = 24,
  parameter int unsigned SHIFT         = 0,
  parameter int unsigned ANGLE_MIN     = 1024,
  parameter int unsigned ANGLE_MAX     = 3072
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        validIn,
  input  logic [11:0] angle1,
  input  logic [11:0] angle2,
  input  logic [11:0] angle3,
  input  logic [11:0] angle4,
  input  logic [11:0] angle5,
  input  logic [11:0] angle6,
  output logic [5:0]  pwm,
  output logic        frameStart,
  output logic        pending
);

  localparam int            CW     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST   = CW'(PERIOD_CYCLES - 1);
  localparam logic [11:0]   CENTRE = 12'd2048;
  localparam logic [63:0]   W_MAX  = 64'(MIN_PULSE) + ((64'd4095 * 64'(SCALE)) >> SHIFT);

  // The widest possible pulse must end before the frame does, or frames would merge.
  generate
    if (W_MAX >= 64'(PERIOD_CYCLES)) begin : g_bad_width
      $error("servo_pwm_six: MIN_PULSE + ((4095*SCALE)>>SHIFT) must be below PERIOD_CYCLES");
    end
    if ((ANGLE_MIN > ANGLE_MAX) || (ANGLE_MAX > 4095)) begin : g_bad_clamp
      $error("servo_pwm_six: clamp bounds must satisfy ANGLE_MIN <= ANGLE_MAX <= 4095");
    end
  endgenerate

  function automatic logic [11:0] f_lim(input logic [11:0] a);
`ifdef SERVO_CLAMP_EN
    logic [11:0] lo;
    logic [11:0] hi;
    lo = 12'(ANGLE_MIN);
    hi = 12'(ANGLE_MAX);
    if (a < lo)      return lo;
    else if (a > hi) return hi;
    else             return a;
`else
    return a;
`endif
  endfunction

  logic [11:0]   w_ang [6];
  logic [11:0]   w_lim [6];
  logic [63:0]   w_width [6];
  logic [5:0]    w_hit;
  logic          w_wrap;

  logic [CW-1:0] r_cnt;
  logic [11:0]   r_shadow [6];
  logic [11:0]   r_active [6];
  logic          r_pending;
  logic [5:0]    r_pwm;

  assign w_ang[0] = angle1;
  assign w_ang[1] = angle2;
  assign w_ang[2] = angle3;
  assign w_ang[3] = angle4;
  assign w_ang[4] = angle5;
  assign w_ang[5] = angle6;

  assign w_wrap = (r_cnt == LAST);

  always_comb begin
    for (int k = 0; k < 6; k++) begin
      w_lim[k]   = f_lim(w_ang[k]);
      w_width[k] = 64'(MIN_PULSE) + ((64'(r_active[k]) * 64'(SCALE)) >> SHIFT);
      w_hit[k]   = (64'(r_cnt) < w_width[k]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  // Active bank only moves on the wrap edge, so a frame never mixes two widths.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        r_shadow[k] <= CENTRE;
        r_active[k] <= CENTRE;
      end
    end else begin
      if (validIn) begin
        for (int k = 0; k < 6; k++) r_shadow[k] <= w_lim[k];
      end
      if (w_wrap) begin
        r_pending <= 1'b0;
        if (validIn) begin
          for (int k = 0; k < 6; k++) r_active[k] <= w_lim[k];
        end else if (r_pending) begin
          for (int k = 0; k < 6; k++) r_active[k] <= r_shadow[k];
        end
      end else if (validIn) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_pwm <= '0;
    else       r_pwm <= w_hit;
  end

  assign pwm        = r_pwm;
  assign pending    = r_pending;
  // Gated by reset so the held-at-zero counter does not report a frame until reset is released.
  assign frameStart = (r_cnt == '0) && !reset;

endmodule

// File: tb/tb_servo_pwm_six.sv
// Directed bench for servo_pwm_six: a negedge monitor measures per-frame pulse widths and
// pops per-frame expectations pushed by the stimulus sequence.
module tb_servo_pwm_six;
  localparam int P = 1000;

  logic             clock   = 1'b0;
  logic             reset   = 1'b1;
  logic             validIn = 1'b0;
  logic [5:0][11:0] ang     = '0;
  logic [5:0]       pwm;
  logic             frameStart;
  logic             pending;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0]      frame;
    logic [5:0][15:0] w;
  } exp_t;
  exp_t sb_q [$];

  int mon_frame = 0;
  bit mon_live  = 0;
  int mon_len   = 0;
  int mon_hi [6];

  servo_pwm_six #(
    .PERIOD_CYCLES(P), .MIN_PULSE(100), .SCALE(1), .SHIFT(4),
    .ANGLE_MIN(1024), .ANGLE_MAX(3072)
  ) dut (
    .clock(clock), .reset(reset), .validIn(validIn),
    .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]),
    .angle4(ang[3]), .angle5(ang[4]), .angle6(ang[5]),
    .pwm(pwm), .frameStart(frameStart), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference width: MIN_PULSE + (angle >> SHIFT), with the clamp when it is built in.
  function automatic int exp_w(input logic [11:0] a);
    int v = int'(a);
`ifdef SERVO_CLAMP_EN
    if (v < 1024) v = 1024;
    if (v > 3072) v = 3072;
`endif
    return 100 + (v >> 4);
  endfunction

  task automatic push_frame(input int f, input logic [5:0][11:0] a);
    exp_t e;
    e.frame = 32'(f);
    for (int ch = 0; ch < 6; ch++) e.w[ch] = 16'(exp_w(a[ch]));
    sb_q.push_back(e);
  endtask

  task automatic finish_frame();
    exp_t e;
    chk($sformatf("frame%0d_len", mon_frame), mon_len, P);
    while (sb_q.size() > 0 && int'(sb_q[0].frame) < mon_frame) begin
      e = sb_q.pop_front();
      chk("expected_frame_never_measured", int'(e.frame), mon_frame);
    end
    if (sb_q.size() > 0 && int'(sb_q[0].frame) == mon_frame) begin
      e = sb_q.pop_front();
      for (int ch = 0; ch < 6; ch++)
        chk($sformatf("frame%0d_width_ch%0d", mon_frame, ch + 1), mon_hi[ch], int'(e.w[ch]));
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      mon_live = 0;
    end else begin
      if (frameStart) begin
        if (mon_live) finish_frame();
        mon_frame++;
        mon_live = 1;
        mon_len  = 0;
        foreach (mon_hi[ch]) mon_hi[ch] = 0;
      end
      if (mon_live) begin
        mon_len++;
        for (int ch = 0; ch < 6; ch++) if (pwm[ch]) mon_hi[ch]++;
      end
    end
  end

  task automatic wait_frame_start();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frameStart && n < P + 10);
    chk("frame_start_seen", int'(frameStart), 1);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [5:0][11:0] a);
    ang     = a;
    validIn = 1'b1;
    @(posedge clock);
    #1 validIn = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    logic [5:0][11:0] pat_mix, pat_alt;
    pat_mix = {12'd4080, 12'd32, 12'd16, 12'd2048, 12'd4095, 12'd0};
    pat_alt = {12'd4095, 12'd0, 12'd4095, 12'd0, 12'd4095, 12'd0};

    // Reset state, then two centre-code frames.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_frameStart", int'(frameStart), 0);
    chk("rst_pending", int'(pending), 0);
    push_frame(1, {6{12'd2048}});
    push_frame(2, {6{12'd2048}});
    @(posedge clock);
    #1 reset = 1'b0;

    // Mid-frame update at cnt=300 of frame 2.
    wait_frame_start();
    wait_frame_start();
    cur = mon_frame;
    adv(300);
    push_frame(cur + 1, pat_mix);
    pulse(pat_mix);
    @(negedge clock);
    chk("pending_after_strobe", int'(pending), 1);
    wait_frame_start();
    chk("pending_after_load", int'(pending), 0);

    // Double strobe in frame 3: last one wins in frame 4.
    cur = mon_frame;
    adv(200);
    pulse({6{12'd0}});
    adv(399);
    push_frame(cur + 1, {6{12'd1600}});
    pulse({6{12'd1600}});

    // Strobe on the wrap cycle of frame 4 applies directly to frame 5.
    wait_frame_start();
    cur = mon_frame;
    adv(999);
    push_frame(cur + 1, {6{12'd4095}});
    pulse({6{12'd4095}});
    @(negedge clock);
    chk("wrap_strobe_pending", int'(pending), 0);
    chk("wrap_strobe_frameStart", int'(frameStart), 1);

    // Reset at cnt=150 of frame 6 with a simultaneous (discarded) strobe.
    wait_frame_start();
    adv(150);
    @(negedge clock);
    chk("pre_reset_pwm", int'(pwm), 6'h3f);
    reset   = 1'b1;
    ang     = '0;
    validIn = 1'b1;
    @(posedge clock);
    #1 validIn = 1'b0;
    @(negedge clock);
    chk("mid_reset_pwm", int'(pwm), 0);
    chk("mid_reset_pending", int'(pending), 0);
    chk("mid_reset_frameStart", int'(frameStart), 0);
    adv(3);
    push_frame(mon_frame + 1, {6{12'd2048}});
    reset = 1'b0;

    // Extreme codes: clamped when built with the clamp, raw otherwise.
    wait_frame_start();
    cur = mon_frame;
    adv(10);
    push_frame(cur + 1, pat_alt);
    pulse(pat_alt);
    wait_frame_start();
    wait_frame_start();

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
